// File: rtl/i2s_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_pkg : shared types, constants and helpers for i2s_tx_fifo     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package i2s_pkg;

  localparam int SAMPLE_W_MAX  = 32;
  localparam int SAMPLE_IDX_W  = 5;
  localparam int I2S_DELAY_STD = 1;
  localparam int LJ_DELAY      = 0;

  // Samples are held MSB-aligned in max-width fields so one bit index serves every SAMPLE_W.
  typedef struct packed {
    logic [SAMPLE_W_MAX-1:0] left;
    logic [SAMPLE_W_MAX-1:0] right;
  } sample_pair_t;

  function automatic int frame_len(input int slot_w);
    return 2 * slot_w;
  endfunction

  function automatic logic [SAMPLE_W_MAX-1:0] msb_align(input logic [SAMPLE_W_MAX-1:0] v,
                                                        input int w);
    return v << (SAMPLE_W_MAX - w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_sample_fifo : synchronous FIFO, valid/ready push, pop strobe  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module i2s_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_fire;
  logic             pop_fire;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = ~full_o;
  assign fill_level_o = count_q;
  assign pop_data_o   = mem_q[rd_ptr_q];

  // A pop on an empty FIFO is ignored, so a same-cycle push is never bypassed.
  assign push_fire = push_valid_i & ~full_o;
  assign pop_fire  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_fire  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_tx_fifo : FIFO-fed I2S / left-justified stereo serialiser     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 17,
  parameter int DELAY      = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int MONO       = 0
) (
  input  logic                              serial_clk,
  input  logic                              reset,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  input  logic [SAMPLE_W-1:0]               sample_left,
  input  logic [SAMPLE_W-1:0]               sample_right,
  output logic                              word_select,
  output logic                              sound_bit_out,
  output logic                              frame_start,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level
);

  localparam int FRAME = frame_len(SLOT_W);
  localparam int POS_W = $clog2(FRAME);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME - 1);
  localparam logic [POS_W-1:0] SLOT_POS = POS_W'(SLOT_W);

  if (SAMPLE_W < 8 || SAMPLE_W > SAMPLE_W_MAX || SAMPLE_W + DELAY > SLOT_W ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("i2s_tx_fifo: illegal parameter combination");
  end

  logic [POS_W-1:0]        pos_q, pos_d;
  sample_pair_t            hold_q, hold_d;
  logic                    ws_q, ws_d;
  logic                    bit_q, bit_d;
  logic                    fs_q, fs_d;
  logic                    ur_q, ur_d;
  logic                    frame_end;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [2*SAMPLE_W-1:0]   push_data;
  logic [2*SAMPLE_W-1:0]   pop_data;
  int                      slot_idx;
  logic [SAMPLE_W_MAX-1:0] cur_sample;
  logic [SAMPLE_IDX_W-1:0] bit_idx;

  if (MONO != 0) begin : g_mono
    assign push_data = {sample_left, {SAMPLE_W{1'b0}}};
  end else begin : g_stereo
    assign push_data = {sample_left, sample_right};
  end

  i2s_sample_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (serial_clk),
    .rst_i        (reset),
    .push_valid_i (sample_valid),
    .push_ready_o (sample_ready),
    .push_data_i  (push_data),
    .pop_i        (frame_end),
    .pop_data_o   (pop_data),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .fill_level_o (fill_level)
  );

  // pos_q is the frame position that the next clock edge drives onto the outputs.
  always_comb begin
    frame_end = (pos_q == LAST_POS);
    pos_d     = frame_end ? '0 : pos_q + 1'b1;
    ur_d      = frame_end & fifo_empty;
    hold_d    = hold_q;
    if (frame_end) begin
      if (fifo_empty) begin
        hold_d = '0;
      end else begin
        hold_d.left  = msb_align(SAMPLE_W_MAX'(pop_data[2*SAMPLE_W-1 -: SAMPLE_W]), SAMPLE_W);
        hold_d.right = msb_align(SAMPLE_W_MAX'(pop_data[SAMPLE_W-1:0]), SAMPLE_W);
      end
    end
  end

  always_comb begin
    ws_d       = (pos_q >= SLOT_POS);
    fs_d       = (pos_q == '0);
    slot_idx   = ws_d ? int'(pos_q) - SLOT_W : int'(pos_q);
    cur_sample = (ws_d && MONO == 0) ? hold_q.right : hold_q.left;
    bit_idx    = SAMPLE_IDX_W'(SAMPLE_W_MAX - 1 - (slot_idx - DELAY));
    bit_d      = 1'b0;
    if (slot_idx >= DELAY && slot_idx < DELAY + SAMPLE_W) begin
      bit_d = cur_sample[bit_idx];
    end
  end

  always_ff @(posedge serial_clk or posedge reset) begin
    if (reset) begin
      pos_q  <= '0;
      hold_q <= '0;
      ws_q   <= 1'b0;
      bit_q  <= 1'b0;
      fs_q   <= 1'b0;
      ur_q   <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      hold_q <= hold_d;
      ws_q   <= ws_d;
      bit_q  <= bit_d;
      fs_q   <= fs_d;
      ur_q   <= ur_d;
    end
  end

  assign word_select   = ws_q;
  assign sound_bit_out = bit_q;
  assign frame_start   = fs_q;
  assign underrun      = ur_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2s_tx_fifo : directed bench for LJ, I2S-delay and mono builds |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_i2s_tx_fifo;

  localparam logic [33:0] WS_EXP   = 34'b00000000000000000_11111111111111111;
  localparam logic [33:0] FS_EXP   = {1'b1, 33'b0};
  localparam logic [33:0] UR_LAST  = 34'd1;
  localparam logic [33:0] DEF_EXP  = 34'b1010010111110000_0_0001001000110100_0;
  localparam logic [33:0] DLY_EXP  = 34'b0_1010010111110000_0_0001001000110100;
  localparam logic [33:0] MONO_EXP = 34'b1000000000000001_0_1000000000000001_0;
  localparam logic [33:0] P1_DEF   = 34'b1100000000000011_0_0000000011111111_0;
  localparam logic [33:0] P1_DLY   = 34'b0_1100000000000011_0_0000000011111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic [15:0] mono_left = 16'h8001;
  logic [15:0] mono_right = 16'hFFFF;

  logic       rdy_def, ws_def, sb_def, fs_def, ur_def;
  logic [2:0] fill_def;
  logic       rdy_dly, ws_dly, sb_dly, fs_dly, ur_dly;
  logic [2:0] fill_dly;
  logic       rdy_mono, ws_mono, sb_mono, fs_mono, ur_mono;
  logic [2:0] fill_mono;

  logic [15:0] pl [5] = '{16'h0F0F, 16'hC003, 16'hFFFF, 16'h1111, 16'h3333};
  logic [15:0] pr [5] = '{16'hF0F0, 16'h00FF, 16'h5555, 16'h2222, 16'h4444};

  logic [33:0] cap_def, cap_dly, cap_mono, cap_ws, cap_fs, cap_ur;
  logic [2:0]  cap_fill0;
  int          pos = 33;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  i2s_tx_fifo #(.SAMPLE_W(16), .SLOT_W(17), .DELAY(0), .FIFO_DEPTH(4), .MONO(0)) u_def (
    .serial_clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(rdy_def),
    .sample_left(sample_left), .sample_right(sample_right), .word_select(ws_def),
    .sound_bit_out(sb_def), .frame_start(fs_def), .underrun(ur_def), .fill_level(fill_def));

  i2s_tx_fifo #(.SAMPLE_W(16), .SLOT_W(17), .DELAY(1), .FIFO_DEPTH(4), .MONO(0)) u_dly (
    .serial_clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(rdy_dly),
    .sample_left(sample_left), .sample_right(sample_right), .word_select(ws_dly),
    .sound_bit_out(sb_dly), .frame_start(fs_dly), .underrun(ur_dly), .fill_level(fill_dly));

  i2s_tx_fifo #(.SAMPLE_W(16), .SLOT_W(17), .DELAY(0), .FIFO_DEPTH(4), .MONO(1)) u_mono (
    .serial_clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(rdy_mono),
    .sample_left(mono_left), .sample_right(mono_right), .word_select(ws_mono),
    .sound_bit_out(sb_mono), .frame_start(fs_mono), .underrun(ur_mono), .fill_level(fill_mono));

  task automatic step();
    @(negedge clk);
    pos = (pos == 33) ? 0 : pos + 1;
  endtask

  task automatic wait_pos(input int n);
    for (int i = 0; i < 40 && pos != n; i++) step();
  endtask

  // Records one full frame starting from the position after p=33; MSB of each vector is p=0.
  task automatic capture(input bit push_first);
    for (int p = 0; p < 34; p++) begin
      step();
      cap_def[33-p]  = sb_def;
      cap_dly[33-p]  = sb_dly;
      cap_mono[33-p] = sb_mono;
      cap_ws[33-p]   = ws_def;
      cap_fs[33-p]   = fs_def;
      cap_ur[33-p]   = ur_def;
      if (p == 0) begin
        cap_fill0 = fill_def;
        if (push_first) sample_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ws_def, sb_def, fs_def, ur_def, fill_def} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b want=0000000", {ws_def, sb_def, fs_def, ur_def, fill_def});
    end
    tests_run++;
    if ({sb_dly, ur_dly, sb_mono, ur_mono} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_other_builds got=%b want=0000", {sb_dly, ur_dly, sb_mono, ur_mono});
    end
    reset = 1'b0;
    pos = 33;
    #1;
    tests_run++;
    if (fill_def !== 3'd0 || rdy_def !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release fill=%0d ready=%b want fill=0 ready=1", fill_def, rdy_def);
    end
  endtask

  task automatic test_silent_frame();
    capture(1'b0);
    tests_run++;
    if ({cap_def, cap_dly, cap_mono} !== '0) begin
      tests_failed++;
      $display("FAIL silent_data def=%h dly=%h mono=%h want 0", cap_def, cap_dly, cap_mono);
    end
    tests_run++;
    if (cap_ws !== WS_EXP) begin
      tests_failed++;
      $display("FAIL word_select got=%b want=%b", cap_ws, WS_EXP);
    end
    tests_run++;
    if (cap_fs !== FS_EXP) begin
      tests_failed++;
      $display("FAIL frame_start got=%b want=%b", cap_fs, FS_EXP);
    end
    tests_run++;
    if (cap_ur !== UR_LAST) begin
      tests_failed++;
      $display("FAIL underrun_frame0 got=%b want=%b", cap_ur, UR_LAST);
    end
  endtask

  task automatic test_push_frame();
    sample_left  = 16'hA5F0;
    sample_right = 16'h1234;
    sample_valid = 1'b1;
    capture(1'b1);
    tests_run++;
    if (cap_fill0 !== 3'd1) begin
      tests_failed++;
      $display("FAIL push_fill got=%0d want=1", cap_fill0);
    end
    tests_run++;
    if (cap_def !== '0 || cap_ur !== '0) begin
      tests_failed++;
      $display("FAIL push_frame data=%h underrun=%h want 0 0", cap_def, cap_ur);
    end
    tests_run++;
    if (fill_def !== 3'd0) begin
      tests_failed++;
      $display("FAIL pop_fill got=%0d want=0", fill_def);
    end
  endtask

  task automatic test_data_frame();
    capture(1'b0);
    tests_run++;
    if (cap_def !== DEF_EXP) begin
      tests_failed++;
      $display("FAIL lj_data got=%b want=%b", cap_def, DEF_EXP);
    end
    tests_run++;
    if (cap_dly !== DLY_EXP) begin
      tests_failed++;
      $display("FAIL i2s_delay_data got=%b want=%b", cap_dly, DLY_EXP);
    end
    tests_run++;
    if (cap_mono !== MONO_EXP) begin
      tests_failed++;
      $display("FAIL mono_data got=%b want=%b", cap_mono, MONO_EXP);
    end
    tests_run++;
    if (cap_ws !== WS_EXP || cap_ur !== UR_LAST) begin
      tests_failed++;
      $display("FAIL data_framing ws=%b ur=%b want ws=%b ur=%b", cap_ws, cap_ur, WS_EXP, UR_LAST);
    end
  endtask

  task automatic test_backpressure();
    sample_left  = pl[0];
    sample_right = pr[0];
    sample_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      sample_left  = pl[k];
      sample_right = pr[k];
    end
    tests_run++;
    if (fill_def !== 3'd4 || rdy_def !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_after_4 fill=%0d ready=%b want fill=4 ready=0", fill_def, rdy_def);
    end
    wait_pos(32);
    tests_run++;
    if (fill_def !== 3'd4 || rdy_def !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_held fill=%0d ready=%b want fill=4 ready=0", fill_def, rdy_def);
    end
    step();
    tests_run++;
    if (fill_def !== 3'd3 || rdy_def !== 1'b1 || ur_def !== 1'b0) begin
      tests_failed++;
      $display("FAIL pop_when_full fill=%0d ready=%b ur=%b want 3 1 0", fill_def, rdy_def, ur_def);
    end
    step();
    tests_run++;
    if (fill_def !== 3'd4 || rdy_def !== 1'b0) begin
      tests_failed++;
      $display("FAIL fifth_push fill=%0d ready=%b want fill=4 ready=0", fill_def, rdy_def);
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_fifo_order();
    wait_pos(33);
    capture(1'b0);
    tests_run++;
    if (cap_def !== P1_DEF || cap_dly !== P1_DLY) begin
      tests_failed++;
      $display("FAIL fifo_order def=%b dly=%b want %b %b", cap_def, cap_dly, P1_DEF, P1_DLY);
    end
    tests_run++;
    if (cap_ur !== '0) begin
      tests_failed++;
      $display("FAIL no_underrun got=%b want=0", cap_ur);
    end
  endtask

  task automatic test_reset_midframe();
    wait_pos(10);
    tests_run++;
    if (sb_def !== 1'b1 || sb_dly !== 1'b1 || ws_def !== 1'b0 || fill_def !== 3'd2) begin
      tests_failed++;
      $display("FAIL pre_reset sb=%b%b ws=%b fill=%0d want 11 0 2", sb_def, sb_dly, ws_def, fill_def);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({ws_def, sb_def, fs_def, ur_def, sb_dly, fill_def} !== 8'b0 || rdy_def !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset got=%b ready=%b want 00000000 1",
               {ws_def, sb_def, fs_def, ur_def, sb_dly, fill_def}, rdy_def);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pos = 33;
    capture(1'b0);
    tests_run++;
    if (cap_def !== '0 || cap_dly !== '0 || cap_fill0 !== 3'd0) begin
      tests_failed++;
      $display("FAIL post_reset_silent def=%h dly=%h fill=%0d want 0 0 0", cap_def, cap_dly, cap_fill0);
    end
    tests_run++;
    if (cap_ur !== UR_LAST || cap_fs !== FS_EXP) begin
      tests_failed++;
      $display("FAIL post_reset_framing ur=%b fs=%b want %b %b", cap_ur, cap_fs, UR_LAST, FS_EXP);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_silent_frame();
    test_push_frame();
    test_data_frame();
    test_backpressure();
    test_fifo_order();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
